// File: rtl/e_8_downcount_timer.sv
// rtl/e_8_downcount_timer.sv - loadable down-counter/timer with pause, prescaler and auto-reload
module e_8_downcount_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx;
    logic [PW-1:0]    prescaler, prescaler_nx;
    logic             tc_nx;
    logic             tick;

    assign tick = (prescaler == PS_MAX);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            prescaler  <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            reload_reg <= reload_nx;
            prescaler  <= prescaler_nx;
            tc         <= tc_nx;
        end
    end

    // load beats pause, pause beats start; pause also blocks start outside RUN
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        reload_nx    = reload_reg;
        prescaler_nx = prescaler;
        tc_nx        = 1'b0;

        if (load) begin
            count_nx     = load_val;
            reload_nx    = load_val;
            prescaler_nx = '0;
            state_nx     = IDLE;
        end else if (pause) begin
            if (state == RUN) begin
                state_nx = PAUSE;
            end
        end else if (state == RUN) begin
            if (tick) begin
                prescaler_nx = '0;
                if (count == WIDTH'(1)) begin
                    tc_nx = 1'b1;
                    if (auto_reload && (reload_reg != '0)) begin
                        count_nx = reload_reg;
                    end else begin
                        count_nx = '0;
                        state_nx = DONE;
                    end
                end else if (count != '0) begin
                    count_nx = count - WIDTH'(1);
                end
            end else begin
                prescaler_nx = prescaler + PW'(1);
            end
        end else if (start) begin
            // a zero count never enters RUN, so it cannot wrap below zero
            if (count != '0) begin
                state_nx = RUN;
            end else begin
                tc_nx    = 1'b1;
                state_nx = DONE;
            end
        end
    end

endmodule

// File: doc/e_8_downcount_timer.md
Name: e_8_downcount_timer

Overview:
- 8-bit loadable down-counter/timer. Complements the existing free-running up-counters: counts a loaded value down to zero and flags terminal count.
- Supports pause/resume, a clock prescaler and auto-reload, for periodic-tick and timeout generation in the lab designs.
- Single clock domain. Outputs drive LEDs/7-seg and downstream control logic.

Parameters:
- WIDTH, 8, counter and load-value width in bits.
- PRESCALE, 1, clk cycles per count tick; legal range 1..65535. A value of 1 means decrement every clk.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load strobe; highest priority.
- load_val  input  WIDTH  value captured by load.
- start  input  1  begin or resume counting.
- pause  input  1  freeze counting while in RUN.
- auto_reload  input  1  1 = reload at terminal count and keep running; sampled at each terminal count.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- tc  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  level, high in DONE state.

Behaviour:
- Reset (async, rst=1):
  - count=0, reload_reg=0, prescaler=0, tc=0, done=0, busy=0.
  - State=IDLE. The reset takes effect immediately, mid-count included.
- Reload register:
  - Internal WIDTH-bit reload_reg is written only by load.
- States: IDLE, RUN, PAUSE, DONE. busy=(state==RUN); done=(state==DONE).
- Input priority per cycle: load > pause > start.
- load (any state):
  - count<=load_val, reload_reg<=load_val, prescaler<=0, state<=IDLE, tc<=0.
  - A load during RUN aborts the run with no tc.
- start in IDLE, PAUSE or DONE:
  - If count!=0: state<=RUN next cycle. The prescaler keeps its held value (0 after load/reset).
  - If count==0: tc pulses 1 cycle, state<=DONE. No wrap to 255.
- start while in RUN: no effect.
- pause in RUN: state<=PAUSE. count and prescaler are held.
- pause in any other state: ignored.
- RUN, tick generation:
  - prescaler increments every clk.
  - tick = (prescaler==PRESCALE-1); the prescaler clears to 0 on tick.
- RUN, on tick with count>1: count<=count-1.
- RUN, on tick with count==1 (terminal count), tc<=1 for exactly that one cycle, and:
  - If auto_reload=1 and reload_reg!=0: count<=reload_reg, stay in RUN. Period = reload_reg*PRESCALE clk cycles.
  - Otherwise: count<=0, state<=DONE.
- Latency:
  - count changes on the clk edge that ends the tick cycle.
  - tc is asserted in the same cycle that count shows 0 (or the reloaded value).
  - First decrement occurs PRESCALE cycles after RUN is entered.
- DONE: count holds 0 until load or reset. start with count==0 gives a fresh tc pulse and stays in DONE.
- Arithmetic:
  - Unsigned count; no underflow is ever produced.
  - Prescaler width is ceil(log2(PRESCALE)), minimum 1.
- tc is never asserted for more than one consecutive cycle unless PRESCALE=1 and reload_reg=1 with auto_reload=1. That case gives tc continuously high with count steady at 1.

Test Plan:
- Reset mid-count:
  - Stimulus: PRESCALE=1, load 8'd10, start, assert rst asynchronously after 4 cycles.
  - Response: count=0, busy=0, done=0, tc=0 immediately, without waiting for a clk edge.
- One-shot countdown:
  - Stimulus: PRESCALE=1, load 8'd5, start.
  - Response: count 5,4,3,2,1,0 on successive cycles. tc=1 only in the cycle count=0; then done=1, busy=0; count holds 0 for 20 cycles.
- Pause/resume and priority:
  - Stimulus: load 8'd200, start, pause at count=150 for 30 cycles, then assert start and pause together.
  - Response: count stays 150 while paused and with both asserted (pause wins). Releasing pause with start high resumes at 149.
- Auto-reload with prescaler:
  - Stimulus: PRESCALE=4, load 8'd3, auto_reload=1, start.
  - Response: tc pulses every 12 cycles; count sequence 3,2,1,3,... with each value held 4 cycles. busy stays 1.
- Load during RUN and zero start:
  - Stimulus: load 8'd50 during RUN at count=20.
  - Response: count=50, state IDLE, no tc.
  - Stimulus: load 8'd0, then start.
  - Response: single tc pulse, done=1, count=0 with no wrap to 8'd255.
- Boundary value:
  - Stimulus: load 8'd255, PRESCALE=1, start.
  - Response: tc exactly 255 cycles after RUN is entered.
